instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_3000, address of first emitted word.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1: request handshake.
REQ-006 SHALL have port in_kind  input  4  instruction kind code (package constants).
REQ-007 SHALL have ports in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-008 SHALL have ports in_imm input 16 and in_target input 26: raw immediate and jump target.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1: word handshake.
REQ-010 SHALL have ports out_instr output 32 and out_addr output 32: head word and its address.
REQ-011 SHALL have ports err output 1 (sticky illegal-kind flag) and err_kind output 4 (first illegal code).

Function
REQ-012 SHALL accept a request when in_valid && in_ready on a rising edge; in_ready = (occupancy != DEPTH), registered-state derived, no combinational path from out_ready.
REQ-013 SHALL encode kinds: 0 nop=32'h0; 1 addu op 0 funct 6'h21; 2 subu op 0 funct 6'h23; 3 ori op 6'h0D; 4 lw op 6'h23; 5 sw op 6'h2B; 6 beq op 6'h04; 7 lui op 6'h0F; 8 jal op 6'h03; 9 jr op 0 funct 6'h08.
REQ-014 SHALL use R-format {op,rs,rt,rd,5'b0,funct} for addu/subu; {op,rs,rt,imm} for ori/lw/sw/beq; {op,5'b0,rt,imm} for lui; {op,target} for jal; {6'b0,rs,15'b0,6'h08} for jr.
REQ-015 SHALL force fields unused by a kind to zero regardless of inputs; immediates SHALL pass unmodified (no extension).
REQ-016 SHALL push the encoded word into the FIFO on acceptance; word SHALL appear at out_instr no earlier than the next cycle (latency 1 when FIFO empty).
REQ-017 SHALL pop the head when out_valid && out_ready; out_valid = (occupancy != 0).
REQ-018 SHALL keep occupancy unchanged on simultaneous push and pop; order SHALL be strictly FIFO.
REQ-019 SHALL hold out_instr/out_addr stable while out_valid && !out_ready.
REQ-020 SHALL set out_addr = BASE_ADDR + 4*(words popped since reset), incrementing by 4 per pop, wrapping modulo 2^32.
REQ-021 SHALL accept kinds 10-15 (handshake completes), push nothing, set err, and capture err_kind only if err was clear.
REQ-022 SHALL accept nothing while full; a dropped illegal request while full is impossible (in_ready=0).

Reset
REQ-023 SHALL, when reset==0 at a rising edge, clear occupancy and pointers, set out_addr=BASE_ADDR, err=0, err_kind=0.
REQ-024 SHALL drive in_ready=1, out_valid=0, out_instr=0 in the cycle after reset.
REQ-025 SHALL discard queued words and any same-cycle handshake when reset asserts mid-operation.

Structure
REQ-026 SHALL place kind codes, opcode/funct constants and BASE_ADDR default in package instr_enc_pkg.
REQ-027 SHALL implement storage in one sub-module instr_fifo (DEPTH x 32, push/pop/full/empty); encoding SHALL be combinational logic in instr_encoder.

Verification
REQ-028 addu rs=1 rt=2 rd=3, out_ready=1 -> next cycle out_instr=32'h0022_1821, out_addr=32'h0000_3000.
REQ-029 ori rt=8 imm=16'h1234 with in_rd=31 -> 32'h3408_1234; lui rs=5 rt=1 imm=16'hFFFF -> 32'h3C01_FFFF (rs masked).
REQ-030 out_ready=0, push 5 words (jal target 26'h0000C03 first) -> in_ready=0 after 4; release -> 32'h0C00_0C03 at 32'h3000, then 3004/3008/300C in order.
REQ-031 jr rs=31 rt=7 rd=9 -> 32'h03E0_0008; beq rs=1 rt=2 imm=16'hFFFF -> 32'h1022_FFFF.
REQ-032 kind 12 then kind 14 -> no word emitted, err=1, err_kind=4'hC; reset low one cycle -> err=0, out_addr=32'h3000, FIFO empty.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared constants for the instruction encoder: request kind codes,
// MIPS opcode/funct fields and the default base address of the output stream.
package instr_enc_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_3000;

    typedef enum logic [3:0] {
        KIND_NOP  = 4'd0,
        KIND_ADDU = 4'd1,
        KIND_SUBU = 4'd2,
        KIND_ORI  = 4'd3,
        KIND_LW   = 4'd4,
        KIND_SW   = 4'd5,
        KIND_BEQ  = 4'd6,
        KIND_LUI  = 4'd7,
        KIND_JAL  = 4'd8,
        KIND_JR   = 4'd9
    } kind_e;

    localparam logic [3:0] KIND_LAST_LEGAL = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

endpackage

// File: rtl/instr_fifo.sv
// Word FIFO holding encoded instructions; the head is presented combinationally
// and reads as zero whenever the FIFO is empty.
module instr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] pop_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    // One extra pointer bit separates the full and empty cases.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into 32-bit MIPS words, queues them in a FIFO
// and streams them out with sequential addresses; illegal kinds raise a sticky error.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [3:0]  err_kind
);

    // Fields a format does not use are dropped here, so stray inputs never leak.
    function automatic logic [31:0] encode(
        input logic [3:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        case (kind_e'(kind))
            KIND_ADDU: return {OP_RTYPE, rs, rt, rd, 5'b0, FN_ADDU};
            KIND_SUBU: return {OP_RTYPE, rs, rt, rd, 5'b0, FN_SUBU};
            KIND_ORI:  return {OP_ORI, rs, rt, imm};
            KIND_LW:   return {OP_LW, rs, rt, imm};
            KIND_SW:   return {OP_SW, rs, rt, imm};
            KIND_BEQ:  return {OP_BEQ, rs, rt, imm};
            KIND_LUI:  return {OP_LUI, 5'b0, rt, imm};
            KIND_JAL:  return {OP_JAL, target};
            KIND_JR:   return {OP_RTYPE, rs, 15'b0, FN_JR};
            default:   return 32'h0;
        endcase
    endfunction

    logic        full;
    logic        empty;
    logic        accept;
    logic        legal;
    logic        push;
    logic        pop;
    logic [31:0] enc_word;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign legal     = (in_kind <= KIND_LAST_LEGAL);
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;
    assign enc_word  = encode(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);

    instr_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(enc_word),
        .pop      (pop),
        .pop_data (out_instr),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_addr <= BASE_ADDR;
            err      <= 1'b0;
            err_kind <= 4'h0;
        end else begin
            if (pop) begin
                out_addr <= out_addr + 32'd4;
            end
            // Only the first illegal code is kept for diagnosis.
            if (accept && !legal && !err) begin
                err      <= 1'b1;
                err_kind <= in_kind;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with hand-computed instruction words.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic [3:0]  err_kind;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_addr;

    always #5 clk = ~clk;

    instr_encoder #(
        .DEPTH    (4),
        .BASE_ADDR(BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_kind  (in_kind),
        .in_rs    (in_rs),
        .in_rt    (in_rt),
        .in_rd    (in_rd),
        .in_imm   (in_imm),
        .in_target(in_target),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_addr (out_addr),
        .err      (err),
        .err_kind (err_kind)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        in_kind   = k;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = tgt;
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        @(negedge clk);
        drive(k, rs, rt, rd, imm, tgt);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp_instr);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_instr"}, out_instr, exp_instr);
        check({tag, "_addr"}, out_addr, exp_addr);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_addr  = exp_addr + 32'd4;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        exp_addr = BASE;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        exp_addr  = BASE;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_addr", out_addr, BASE);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_err_kind", {28'b0, err_kind}, 32'd0);

        // addu with the consumer ready: visible one cycle later, then drained
        @(negedge clk);
        out_ready = 1'b1;
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        check("addu_valid", {31'b0, out_valid}, 32'd1);
        check("addu_instr", out_instr, 32'h0022_1821);
        check("addu_addr", out_addr, 32'h0000_3000);
        @(posedge clk);
        #1;
        check("addu_drained", {31'b0, out_valid}, 32'd0);
        check("addu_next_addr", out_addr, 32'h0000_3004);
        out_ready = 1'b0;
        exp_addr  = 32'h0000_3004;

        send(4'd3, 5'd0, 5'd8, 5'd31, 16'h1234, 26'h3FF_FFFF);
        pop_check("ori", 32'h3408_1234);
        send(4'd7, 5'd5, 5'd1, 5'd31, 16'hFFFF, 26'h0);
        pop_check("lui", 32'h3C01_FFFF);
        send(4'd9, 5'd31, 5'd7, 5'd9, 16'hFFFF, 26'h3FF_FFFF);
        pop_check("jr", 32'h03E0_0008);
        send(4'd6, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        pop_check("beq", 32'h1022_FFFF);
        send(4'd4, 5'd2, 5'd3, 5'd7, 16'h0010, 26'h0);
        pop_check("lw", 32'h8C43_0010);
        send(4'd2, 5'd4, 5'd5, 5'd6, 16'hFFFF, 26'h3FF_FFFF);
        pop_check("subu", 32'h0085_3023);
        send(4'd5, 5'd29, 5'd31, 5'd0, 16'hFFFC, 26'h0);
        pop_check("sw", 32'hAFBF_FFFC);
        send(4'd0, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FF_FFFF);
        pop_check("nop", 32'h0000_0000);
        check("drained_after_nop", {31'b0, out_valid}, 32'd0);

        // Reset mid-operation drops queued words and a same-cycle request
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        send(4'd3, 5'd0, 5'd8, 5'd0, 16'h1234, 26'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(4'd1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        exp_addr = BASE;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_out_instr", out_instr, 32'h0);
        check("midrst_out_addr", out_addr, BASE);

        // Fill with the consumer stalled; fifth request waits for space
        send(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0C03);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        send(4'd3, 5'd0, 5'd8, 5'd31, 16'h1234, 26'h0);
        check("fill3_in_ready", {31'b0, in_ready}, 32'd1);
        send(4'd9, 5'd31, 5'd7, 5'd9, 16'h0, 26'h0);
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        drive(4'd7, 5'd5, 5'd1, 5'd0, 16'hFFFF, 26'h0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("full_hold_in_ready", {31'b0, in_ready}, 32'd0);
        check("stall_instr", out_instr, 32'h0C00_0C03);
        check("stall_addr", out_addr, 32'h0000_3000);
        pop_check("jal", 32'h0C00_0C03);
        check("space_in_ready", {31'b0, in_ready}, 32'd1);
        check("fill_addu_instr", out_instr, 32'h0022_1821);
        check("fill_addu_addr", out_addr, 32'h0000_3004);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_addr  = exp_addr + 32'd4;
        pop_check("fill_ori", 32'h3408_1234);
        pop_check("fill_jr", 32'h03E0_0008);
        pop_check("fill_lui", 32'h3C01_FFFF);
        check("fill_empty", {31'b0, out_valid}, 32'd0);
        check("fill_end_addr", out_addr, 32'h0000_3014);

        // Illegal kinds complete the handshake but produce no word
        send(4'd12, 5'd1, 5'd2, 5'd3, 16'h1, 26'h1);
        check("ill_in_ready", {31'b0, in_ready}, 32'd1);
        send(4'd14, 5'd1, 5'd2, 5'd3, 16'h1, 26'h1);
        check("ill_out_valid", {31'b0, out_valid}, 32'd0);
        check("ill_err", {31'b0, err}, 32'd1);
        check("ill_err_kind", {28'b0, err_kind}, 32'h0000_000C);
        do_reset();
        check("ill_rst_err", {31'b0, err}, 32'd0);
        check("ill_rst_err_kind", {28'b0, err_kind}, 32'd0);
        check("ill_rst_addr", out_addr, BASE);
        check("ill_rst_out_valid", {31'b0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
